// File: rtl/sonic_ranger_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sonic_ranger_ctrl
// Purpose : periodic ultrasonic ranging, echo-to-mm scaling, 4-tap average
// Rev     : 1.0  initial release
// ============================================================================
module sonic_ranger_ctrl #(
   parameter int unsigned PERIOD_CYCLES  = 10000000,
   parameter int unsigned TIMEOUT_CYCLES = 3000000,
   parameter int unsigned MAX_ECHO       = 1850000,
   parameter int unsigned SCALE_K        = 1798,
   parameter int unsigned SCALE_SHIFT    = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        one_shot,
   output logic        req,
   input  logic        busy,
   input  logic        finish,
   input  logic [31:0] sensor_data,
   output logic [15:0] dist_mm,
   output logic [15:0] dist_avg_mm,
   output logic        valid,
   output logic        range_err,
   output logic        timeout_err,
   output logic [7:0]  sample_cnt
);

   localparam logic [31:0] c_period_last = 32'(PERIOD_CYCLES - 1);
   localparam logic [31:0] c_tmo_last    = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] c_max_echo    = 32'(MAX_ECHO);
   localparam logic [42:0] c_scale_k     = 43'(SCALE_K);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_CALC      = 3'd3,
      S_AVG       = 3'd4,
      S_PUBLISH   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       period_cnt_q, period_cnt_d;
   logic              pending_q, pending_d;
   logic [31:0]       tmo_cnt_q, tmo_cnt_d;
   logic [31:0]       echo_q, echo_d;
   logic [42:0]       prod_q, prod_d;
   logic              oor_q, oor_d;
   logic              primed_q, primed_d;
   logic [3:0][15:0]  win_q, win_d;
   logic [15:0]       dist_q, dist_d;
   logic [15:0]       avg_q, avg_d;
   logic              range_q, range_d;
   logic              tout_q, tout_d;
   logic              tpulse_q, tpulse_d;
   logic [7:0]        cnt_q, cnt_d;

   logic              w_tick;
   logic              w_take;
   logic              w_tmo;
   logic [42:0]       w_scaled;
   logic [15:0]       w_mm;
   logic [17:0]       w_sum;

   // A tick landing in the same cycle IDLE consumes the request re-arms pending.
   always_comb begin
      w_tick       = 1'b0;
      period_cnt_d = period_cnt_q;
      if (!enable) begin
         period_cnt_d = '0;
      end else if (period_cnt_q >= c_period_last) begin
         period_cnt_d = '0;
         w_tick       = 1'b1;
      end else begin
         period_cnt_d = period_cnt_q + 32'd1;
      end
      w_take    = (state_q == S_IDLE) && pending_q && !busy;
      pending_d = (pending_q && !w_take) || w_tick || one_shot;
   end

   assign w_tmo    = (tmo_cnt_q >= c_tmo_last);
   assign w_scaled = prod_q >> SCALE_SHIFT;
   assign w_mm     = (|w_scaled[42:16]) ? 16'hFFFF : w_scaled[15:0];
   // Window slot 0 is the newest sample; an unprimed window is four copies of it.
   assign w_sum    = primed_q ? (18'(w_mm) + 18'(win_q[0]) + 18'(win_q[1]) + 18'(win_q[2]))
                              : {w_mm, 2'b00};

   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      echo_d    = echo_q;
      prod_d    = prod_q;
      oor_d     = oor_q;
      primed_d  = primed_q;
      win_d     = win_q;
      dist_d    = dist_q;
      avg_d     = avg_q;
      range_d   = range_q;
      tout_d    = tout_q;
      tpulse_d  = 1'b0;
      cnt_d     = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (w_take) begin
               tmo_cnt_d = '0;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (w_tmo) begin
               tout_d   = 1'b1;
               tpulse_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
               if (busy) state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (finish) begin
               echo_d  = sensor_data;
               state_d = S_CALC;
            end else if (w_tmo) begin
               tout_d   = 1'b1;
               tpulse_d = 1'b1;
               state_d  = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
         end
         S_CALC: begin
            if (echo_q >= c_max_echo) begin
               oor_d = 1'b1;
            end else begin
               oor_d  = 1'b0;
               prod_d = 43'(echo_q) * c_scale_k;
               tout_d = 1'b0;
            end
            state_d = S_AVG;
         end
         S_AVG: begin
            // Results are registered here so they appear together with valid.
            range_d = oor_q;
            cnt_d   = cnt_q + 8'd1;
            if (!oor_q) begin
               win_d    = primed_q ? {win_q[2], win_q[1], win_q[0], w_mm} : {4{w_mm}};
               primed_d = 1'b1;
               dist_d   = w_mm;
               avg_d    = w_sum[17:2];
            end
            state_d = S_PUBLISH;
         end
         S_PUBLISH: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         period_cnt_q <= '0;
         pending_q    <= 1'b0;
         tmo_cnt_q    <= '0;
         echo_q       <= '0;
         prod_q       <= '0;
         oor_q        <= 1'b0;
         primed_q     <= 1'b0;
         win_q        <= '0;
         dist_q       <= '0;
         avg_q        <= '0;
         range_q      <= 1'b0;
         tout_q       <= 1'b0;
         tpulse_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         pending_q    <= pending_d;
         tmo_cnt_q    <= tmo_cnt_d;
         echo_q       <= echo_d;
         prod_q       <= prod_d;
         oor_q        <= oor_d;
         primed_q     <= primed_d;
         win_q        <= win_d;
         dist_q       <= dist_d;
         avg_q        <= avg_d;
         range_q      <= range_d;
         tout_q       <= tout_d;
         tpulse_q     <= tpulse_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req         = (state_q == S_REQ);
   assign valid       = (state_q == S_PUBLISH) || tpulse_q;
   assign dist_mm     = dist_q;
   assign dist_avg_mm = avg_q;
   assign range_err   = range_q;
   assign timeout_err = tout_q;
   assign sample_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sonic_ranger_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sonic_ranger_ctrl
// Purpose : randomized traffic for sonic_ranger_ctrl against a ranging model
// Rev     : 1.0  initial release
// ============================================================================
module tb_sonic_ranger_ctrl;

   localparam int PERIOD = 50;
   localparam int TMO    = 100;
   localparam int MAXE   = 1850000;
   localparam int K      = 1798;
   localparam int SH     = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        one_shot = 1'b0;
   logic        busy = 1'b0;
   logic        finish = 1'b0;
   logic [31:0] sensor_data = '0;
   logic        req, valid, range_err, timeout_err;
   logic [15:0] dist_mm, dist_avg_mm;
   logic [7:0]  sample_cnt;

   always #5 clk = ~clk;

   sonic_ranger_ctrl #(
      .PERIOD_CYCLES (PERIOD),
      .TIMEOUT_CYCLES(TMO),
      .MAX_ECHO      (MAXE),
      .SCALE_K       (K),
      .SCALE_SHIFT   (SH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .one_shot   (one_shot),
      .req        (req),
      .busy       (busy),
      .finish     (finish),
      .sensor_data(sensor_data),
      .dist_mm    (dist_mm),
      .dist_avg_mm(dist_avg_mm),
      .valid      (valid),
      .range_err  (range_err),
      .timeout_err(timeout_err),
      .sample_cnt (sample_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- sensor stage model ----------------
   // mode 0: normal, 1: ignores req, 2: raises busy but never finishes
   int          sens_mode = 0;
   int          sens_lat  = 5;
   int unsigned echo_fifo[$];

   initial begin : sensor
      forever begin
         @(negedge clk);
         if (req && sens_mode != 1) begin
            @(posedge clk); #1 busy = 1'b1;
            if (sens_mode == 2) begin
               repeat (TMO + 20) @(posedge clk);
               #1 busy = 1'b0;
            end else begin
               repeat (sens_lat) @(posedge clk);
               #1 finish = 1'b1;
               sensor_data = (echo_fifo.size() > 0) ? echo_fifo.pop_front() : $urandom_range(2000000, 0);
               @(posedge clk); #1 finish = 1'b0;
               busy = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model + monitor ----------------
   int cyc = 0, exp_due = -1, tmo_due = -1, last_pub = -1;
   bit prev_req = 1'b0, chk_gap = 1'b0;
   int n_req = 0, n_fin = 0, n_val = 0;
   int win[$];
   int m_dist = 0, m_avg = 0, m_cnt = 0;
   bit m_range = 1'b0, m_tout = 1'b0;

   function automatic void model_sample(input int unsigned d);
      longint mm;
      int     sum;
      if (d >= MAXE) begin
         m_range = 1'b1;
      end else begin
         mm = (longint'(d) * K) >> SH;
         if (mm > 65535) mm = 65535;
         if (win.size() == 0) repeat (4) win.push_back(int'(mm));
         else begin
            win.push_back(int'(mm));
            void'(win.pop_front());
         end
         sum = 0;
         foreach (win[i]) sum += win[i];
         m_avg   = sum / 4;
         m_dist  = int'(mm);
         m_range = 1'b0;
         m_tout  = 1'b0;
      end
      m_cnt = (m_cnt + 1) % 256;
   endfunction

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            win.delete();
            m_dist = 0; m_avg = 0; m_cnt = 0; m_range = 1'b0; m_tout = 1'b0;
            exp_due = -1; tmo_due = -1; prev_req = 1'b0;
         end else begin
            if (req && !prev_req) begin
               n_req++;
               tmo_due = cyc + TMO;
               if (chk_gap && last_pub >= 0) chk_eq("req_gap", 64'(cyc - last_pub), 64'd2);
            end
            prev_req = req;
            if (finish) begin
               n_fin++;
               tmo_due = -1;
               exp_due = cyc + 3;
               model_sample(sensor_data);
            end
            if (cyc == tmo_due) begin
               exp_due = cyc;
               tmo_due = -1;
               m_tout  = 1'b1;
            end
            if (valid) begin
               chk_eq("valid_cycle", 64'(cyc), 64'(exp_due));
               chk_eq("dist_mm", 64'(dist_mm), 64'(m_dist));
               chk_eq("dist_avg_mm", 64'(dist_avg_mm), 64'(m_avg));
               chk_eq("range_err", 64'(range_err), 64'(m_range));
               chk_eq("timeout_err", 64'(timeout_err), 64'(m_tout));
               chk_eq("sample_cnt", 64'(sample_cnt), 64'(m_cnt));
               exp_due  = -1;
               last_pub = cyc;
               n_val++;
            end else if (cyc == exp_due) begin
               chk_eq("valid_missing", 64'(valid), 64'd1);
               exp_due = -1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse_one_shot();
      @(posedge clk); #1 one_shot = 1'b1;
      @(posedge clk); #1 one_shot = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc, input string tag);
      int k = 0;
      while (!valid && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      chk_eq(tag, 64'(valid), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk_eq({tag, "_req"}, 64'(req), 64'd0);
      chk_eq({tag, "_valid"}, 64'(valid), 64'd0);
      chk_eq({tag, "_dist"}, 64'(dist_mm), 64'd0);
      chk_eq({tag, "_avg"}, 64'(dist_avg_mm), 64'd0);
      chk_eq({tag, "_range"}, 64'(range_err), 64'd0);
      chk_eq({tag, "_tout"}, 64'(timeout_err), 64'd0);
      chk_eq({tag, "_cnt"}, 64'(sample_cnt), 64'd0);
   endtask

   task automatic measure(input int unsigned echo, input int lat, input string tag);
      sens_mode = 0;
      sens_lat  = lat;
      echo_fifo.push_back(echo);
      pulse_one_shot();
      wait_valid(lat + 40, tag);
      @(negedge clk);
   endtask

   initial begin : main
      int base_req, base_val, base_fin, req_at_off, k;
      int unsigned e;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // 1000 mm reference point
      measure(583090, 5, "tp1");
      chk_eq("tp1_dist", 64'(dist_mm), 64'd999);
      chk_eq("tp1_avg", 64'(dist_avg_mm), 64'd999);
      chk_eq("tp1_cnt", 64'(sample_cnt), 64'd1);

      // four-sample window: 199/399/599/799 mm
      measure(116618, 3, "tp2a");
      measure(233236, 7, "tp2b");
      measure(349854, 2, "tp2c");
      measure(466472, 9, "tp2d");
      chk_eq("tp2_avg", 64'(dist_avg_mm), 64'd499);

      // boundary echo is out of range
      measure(1850000, 4, "tp3");
      chk_eq("tp3_range", 64'(range_err), 64'd1);
      chk_eq("tp3_dist", 64'(dist_mm), 64'd799);
      chk_eq("tp3_cnt", 64'(sample_cnt), 64'd6);
      measure(1849999, 4, "tp3b");
      chk_eq("tp3b_range", 64'(range_err), 64'd0);

      // timeout in REQ, then in WAIT_DONE, then recovery
      sens_mode = 1;
      pulse_one_shot();
      wait_valid(TMO + 20, "tmo_req");
      chk_eq("tmo_req_err", 64'(timeout_err), 64'd1);
      chk_eq("tmo_req_cnt", 64'(sample_cnt), 64'd7);
      @(negedge clk);
      sens_mode = 2;
      pulse_one_shot();
      wait_valid(TMO + 20, "tmo_wait");
      chk_eq("tmo_wait_err", 64'(timeout_err), 64'd1);
      @(negedge clk);
      k = 0;
      while (busy && k < 100) begin @(negedge clk); k++; end
      measure(583090, 6, "tmo_recover");
      chk_eq("tmo_recover_err", 64'(timeout_err), 64'd0);

      // randomized one-shot traffic
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(6, 0)) @(posedge clk);
         if ($urandom_range(9, 0) == 0) begin
            sens_mode = 1;
            pulse_one_shot();
            wait_valid(TMO + 20, "rnd_tmo");
            @(negedge clk);
         end else begin
            e = ($urandom_range(4, 0) == 0) ? $urandom_range(2000000, MAXE) : $urandom_range(MAXE - 1, 0);
            measure(e, $urandom_range(20, 1), "rnd");
         end
      end

      // periodic mode with sensor slower than the period
      sens_mode = 0;
      sens_lat  = 80;
      last_pub  = -1;
      chk_gap   = 1'b1;
      base_req  = n_req; base_val = n_val; base_fin = n_fin;
      @(posedge clk); #1 enable = 1'b1;
      repeat (1500 + $urandom_range(60, 0)) @(posedge clk);
      #1 enable = 1'b0;
      req_at_off = n_req;
      repeat (300) @(posedge clk);
      chk_gap = 1'b0;
      chk_eq("per_req_vs_valid", 64'(n_req - base_req), 64'(n_val - base_val));
      chk_eq("per_fin_vs_valid", 64'(n_fin - base_fin), 64'(n_val - base_val));
      chk_eq("per_progress", 64'((n_val - base_val) >= 10), 64'd1);
      chk_eq("per_extra_req", 64'((n_req - req_at_off) <= 1), 64'd1);

      // asynchronous reset while waiting for finish
      sens_lat = 60;
      pulse_one_shot();
      k = 0;
      while (!busy && k < 20) begin @(negedge clk); k++; end
      chk_eq("rst_busy_seen", 64'(busy), 64'd1);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      k = 0;
      while (busy && k < 100) begin @(negedge clk); k++; end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      measure(583090, 5, "post_rst");
      chk_eq("post_rst_dist", 64'(dist_mm), 64'd999);
      chk_eq("post_rst_avg", 64'(dist_avg_mm), 64'd999);
      chk_eq("post_rst_cnt", 64'(sample_cnt), 64'd1);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
